// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient controller: state encoding and
// the small elaboration-time helpers used to size the flush counter.
package fir_ctrl_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_SWAP  = 2'd2;

   typedef enum logic [1:0] {
      S_RUN   = ST_RUN,
      S_FLUSH = ST_FLUSH,
      S_SWAP  = ST_SWAP
   } ctrl_state_t;

   // Zero samples needed to push every in-flight product out of the FIR.
   function automatic int flush_cycles(input int coeff_num, input int latency);
      return coeff_num - 1 + latency;
   endfunction

   // Ceiling log2, never below 1 so the result is always a usable width.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value)
         result = result + 1;
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair: host writes go to shadow, a swap
// copies the whole shadow set into the active set that drives the FIR.
module fir_coeff_bank
   import fir_ctrl_pkg::*;
#(
   parameter int COEFF_NUM  = 8,
   parameter int COEFF_BITS = 16,
   parameter int ADDR_BITS  = 3
)
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            we,
   input  logic [ADDR_BITS-1:0]            addr,
   input  logic [COEFF_BITS-1:0]           wdata,
   input  logic                            swap,
   output logic [COEFF_BITS-1:0]           rdata,
   output logic [COEFF_NUM*COEFF_BITS-1:0] coeffs
);

   // Shadow spans the full address space; entries past COEFF_NUM are never
   // written, so out-of-range reads naturally return zero.
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [COEFF_BITS-1:0] shadow_reg [DEPTH];
   logic [COEFF_BITS-1:0] active_reg [COEFF_NUM];
   logic [COEFF_BITS-1:0] rdata_reg;
   logic                  addr_ok;

   assign addr_ok = (32'(addr) < COEFF_NUM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            shadow_reg[i] <= '0;
         for (int i = 0; i < COEFF_NUM; i++)
            active_reg[i] <= '0;
         rdata_reg <= '0;
      end else begin
         // Swap samples the pre-write shadow, so a write in the same cycle
         // only reaches the shadow copy.
         if (swap) begin
            for (int i = 0; i < COEFF_NUM; i++)
               active_reg[i] <= shadow_reg[i];
         end
         if (we && addr_ok)
            shadow_reg[addr] <= wdata;
         rdata_reg <= shadow_reg[addr];
      end
   end

   assign rdata = rdata_reg;

   generate
      for (genvar gi = 0; gi < COEFF_NUM; gi++) begin : g_tap
         assign coeffs[gi*COEFF_BITS +: COEFF_BITS] = active_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: gates the FIR clock enable from the input
// stream and performs flush-then-swap coefficient updates on commit.
module fir_coeff_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int COEFF_NUM  = 8,
   parameter int COEFF_BITS = 16,
   parameter int DIN_BITS   = 16,
   parameter int LATENCY    = 4,
   parameter int ADDR_BITS  = 3
)
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            in_valid,
   input  logic [DIN_BITS-1:0]             in_data,
   output logic                            in_ready,
   input  logic                            cfg_we,
   input  logic [ADDR_BITS-1:0]            cfg_addr,
   input  logic [COEFF_BITS-1:0]           cfg_wdata,
   output logic [COEFF_BITS-1:0]           cfg_rdata,
   input  logic                            cfg_commit,
   output logic                            cfg_busy,
   output logic                            commit_done,
   output logic                            fir_clken,
   output logic [DIN_BITS-1:0]             fir_din,
   output logic [COEFF_NUM*COEFF_BITS-1:0] fir_coeffs,
   output logic                            flush_active
);

   localparam int FLUSH_CYCLES = flush_cycles(COEFF_NUM, LATENCY);
   localparam int CNT_BITS     = clog2(FLUSH_CYCLES);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(FLUSH_CYCLES - 1);

   ctrl_state_t         state_reg, state_next;
   logic [CNT_BITS-1:0] cnt_reg, cnt_next;
   logic                commit_done_reg, commit_done_next;
   logic                swap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= S_RUN;
         cnt_reg         <= '0;
         commit_done_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         commit_done_reg <= commit_done_next;
      end
   end

   // Commits arriving outside RUN are dropped, not queued.
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      commit_done_next = 1'b0;
      swap             = 1'b0;
      case (state_reg)
         S_RUN: begin
            if (cfg_commit) begin
               state_next = S_FLUSH;
               cnt_next   = CNT_LOAD;
            end
         end
         S_FLUSH: begin
            if (cnt_reg == '0)
               state_next = S_SWAP;
            else
               cnt_next = cnt_reg - CNT_BITS'(1);
         end
         S_SWAP: begin
            swap             = 1'b1;
            state_next       = S_RUN;
            commit_done_next = 1'b1;
         end
         default: state_next = S_RUN;
      endcase
   end

   // Stream-side outputs are held low while reset is asserted.
   always_comb begin
      in_ready     = 1'b0;
      fir_clken    = 1'b0;
      fir_din      = '0;
      flush_active = 1'b0;
      if (reset_n) begin
         case (state_reg)
            S_RUN: begin
               in_ready  = 1'b1;
               fir_clken = in_valid;
               fir_din   = in_data;
            end
            S_FLUSH: begin
               fir_clken    = 1'b1;
               flush_active = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cfg_busy    = (state_reg != S_RUN);
   assign commit_done = commit_done_reg;

   fir_coeff_bank #(
      .COEFF_NUM  (COEFF_NUM),
      .COEFF_BITS (COEFF_BITS),
      .ADDR_BITS  (ADDR_BITS)
   ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (cfg_we),
      .addr    (cfg_addr),
      .wdata   (cfg_wdata),
      .swap    (swap),
      .rdata   (cfg_rdata),
      .coeffs  (fir_coeffs)
   );

endmodule
